// File: rtl/lfsr_share_ctrl_if.sv
// Request/response/seed bundle between requesters and the shared LFSR controller.
// The master side drives requests, seed loads and response acceptance.
interface lfsr_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
) ();
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               seed_valid;
  logic [WIDTH-1:0]   seed_data;
  logic               seed_ready;
  logic               busy;
  logic [WIDTH-1:0]   lfsr_state;

  modport master (
    output req, rsp_ready, seed_valid, seed_data,
    input  gnt, rsp_valid, rsp_data, rsp_id, seed_ready, busy, lfsr_state
  );

  modport slave (
    input  req, rsp_ready, seed_valid, seed_data,
    output gnt, rsp_valid, rsp_data, rsp_id, seed_ready, busy, lfsr_state
  );
endinterface

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one Fibonacci LFSR; each grant shifts out a WIDTH-bit word, one bit per cycle.
// Grant one edge after req is seen in IDLE, rsp_valid WIDTH edges later; RESP holds everything until rsp_ready.
module lfsr_share_ctrl #(
  parameter int              NUM_REQ = 4,
  parameter int              WIDTH   = 5,
  parameter logic [WIDTH-1:0] TAPS   = 5'b10010,
  parameter logic [WIDTH-1:0] SEED   = 5'b00001
) (
  input logic              clk,
  input logic              rst,
  lfsr_share_ctrl_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t           st;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  int               idx;

  assign lfsr_next      = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign bus.lfsr_state = lfsr;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      lfsr           <= SEED;
      shreg          <= '0;
      cnt            <= '0;
      ptr            <= IDW'(NUM_REQ - 1);
      bus.gnt        <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_id     <= '0;
      bus.busy       <= 1'b0;
      bus.seed_ready <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (bus.seed_valid) begin
            // An all-zero seed would lock the LFSR, so fall back to SEED.
            lfsr <= (bus.seed_data == '0) ? SEED : bus.seed_data;
          end else if (win_found) begin
            bus.gnt        <= NUM_REQ'(1) << win_idx;
            bus.rsp_id     <= win_idx;
            ptr            <= win_idx;
            cnt            <= '0;
            shreg          <= '0;
            bus.busy       <= 1'b1;
            bus.seed_ready <= 1'b0;
            st             <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], lfsr[WIDTH-1]};
          lfsr  <= lfsr_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= {shreg[WIDTH-2:0], lfsr[WIDTH-1]};
            st            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.gnt        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.seed_ready <= 1'b1;
            st             <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
